// File: rtl/ucode_loader.sv
// Microcode loader: parses a framed byte stream (start, count, data, checksum) and
// writes 32-bit words into microcode memory, holding the sequencer until a verified load.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for START_BYTE; other bytes silently dropped
// S_CNT_HI | capturing high byte of word count
// S_CNT_LO | capturing low byte, validating count
// S_DATA   | assembling words MSB-first, writing every 4th byte
// S_CHK    | comparing the checksum byte with the running XOR
module ucode_loader #(
   parameter int          ADDR_W     = 9,
   parameter logic [7:0]  START_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic              seq_hold_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int          CW  = ADDR_W + 1;
   localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_HI,
      S_CNT_LO,
      S_DATA,
      S_CHK
   } state_t;

   state_t              state_q;
   logic [7:0]          cnt_hi_q;
   logic [CW-1:0]       words_left_q;
   logic [ADDR_W-1:0]   word_idx_q;
   logic [1:0]          byte_idx_q;
   logic [23:0]         asm_q;
   logic [7:0]          xor_q;

   logic                xfer_d;
   logic [15:0]         count_d;
   logic                count_ok_d;
   logic [31:0]         word_d;
   logic [7:0]          xor_d;

   always_comb begin
      xfer_d     = in_valid_i && in_ready_o;
      count_d    = {cnt_hi_q, in_data_i};
      count_ok_d = (count_d != 16'd0) && ({1'b0, count_d} <= CAP);
      word_d     = {asm_q, in_data_i};
      xor_d      = xor_q ^ in_data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_hi_q     <= '0;
         words_left_q <= '0;
         word_idx_q   <= '0;
         byte_idx_q   <= '0;
         asm_q        <= '0;
         xor_q        <= '0;
         in_ready_o   <= 1'b0;
         wr_en_o      <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= '0;
         seq_hold_o   <= 1'b1;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         in_ready_o <= 1'b1;
         wr_en_o    <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         if (xfer_d) begin
            unique case (state_q)
               S_IDLE: begin
                  if (in_data_i == START_BYTE) begin
                     seq_hold_o <= 1'b1;
                     state_q    <= S_CNT_HI;
                  end
               end
               S_CNT_HI: begin
                  cnt_hi_q <= in_data_i;
                  state_q  <= S_CNT_LO;
               end
               S_CNT_LO: begin
                  if (count_ok_d) begin
                     words_left_q <= count_d[CW-1:0];
                     word_idx_q   <= '0;
                     byte_idx_q   <= '0;
                     xor_q        <= '0;
                     state_q      <= S_DATA;
                  end else begin
                     err_o   <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
               S_DATA: begin
                  asm_q      <= word_d[23:0];
                  xor_q      <= xor_d;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     wr_en_o      <= 1'b1;
                     wr_addr_o    <= word_idx_q;
                     wr_data_o    <= word_d;
                     word_idx_q   <= word_idx_q + 1'b1;
                     words_left_q <= words_left_q - 1'b1;
                     // Terminal count: the word just written was the last one.
                     if (words_left_q == CW'(1)) begin
                        state_q <= S_CHK;
                     end
                  end
               end
               S_CHK: begin
                  if (in_data_i == xor_q) begin
                     done_o     <= 1'b1;
                     seq_hold_o <= 1'b0;
                  end else begin
                     err_o <= 1'b1;
                  end
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/ucode_loader.md
# ucode_loader

Loads microcode words into the sequencer's 32-bit-wide microcode memory from a byte stream, on the same memory port the sequencer fetches from. It parses a framed stream (start byte, word count, data, checksum) and writes each assembled word to memory. It holds the sequencer stopped from reset until a load completes with a good checksum, so the sequencer only ever runs a fully verified program.

## Interface
- ADDR_W, 9, microcode address width; capacity is 2**ADDR_W words.
- START_BYTE, 8'hA5, frame start marker.

- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- wr_en  out  1  microcode memory write strobe.
- wr_addr  out  ADDR_W  write word address.
- wr_data  out  32  write word: {pwm2[4], pwm1[4], vec[12], opcode[3], arg[9]}.
- seq_hold  out  1  holds the sequencer stopped (drives its fetch and reset logic).
- done  out  1  one-cycle pulse: load finished with a good checksum.
- err  out  1  one-cycle pulse: frame rejected.

## Operation
- Frame format: START_BYTE, CNT_HI, CNT_LO, 4×N data bytes, CHK.
  - N = {CNT_HI, CNT_LO}.
  - Each word is sent MSB byte first.
  - CHK is the XOR of all 4×N data bytes only.
- States: IDLE, CNT_HI, CNT_LO, DATA, CHK.
  - IDLE: a byte equal to START_BYTE moves to CNT_HI. Any other byte is discarded, with no flag raised.
  - CNT_HI: store the byte, then go to CNT_LO.
  - CNT_LO: store the byte and form N.
    - If N == 0 or N > 2**ADDR_W: pulse err and return to IDLE.
    - Otherwise clear the byte index, word index and running XOR, then go to DATA.
  - DATA: shift each byte into a 32-bit assembly register and XOR it into the running checksum.
    - On the 4th byte, issue a write and increment the word index.
    - After word N-1 is written, go to CHK.
    - A byte equal to START_BYTE inside DATA is ordinary data; there is no resynchronisation.
  - CHK: compare the byte with the running XOR.
    - Match: pulse done, clear seq_hold, return to IDLE.
    - Mismatch: pulse err, return to IDLE; seq_hold stays 1.
- seq_hold:
  - Set to 1 on the cycle after a START_BYTE is accepted in IDLE.
  - Cleared only on a good checksum.
  - Remains 1 after any error, so a partially written program never runs.
- in_ready is 1 in every state while out of reset. Stalls come only from the source, via in_valid = 0, which may occur between any two bytes.
- Word index width is ADDR_W+1 bits so N = 2**ADDR_W can be counted. wr_addr is the low ADDR_W bits of the word index, and never wraps within a valid frame.

## Timing
- Reset values: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, seq_hold 1, done 0, err 0.
  - in_ready goes to 1 on the first clk edge after reset_n deasserts.
- Write latency:
  - wr_en is high for exactly one cycle: the cycle after the edge that accepts the 4th byte of a word.
  - wr_addr and wr_data are valid in that same cycle.
  - With back-to-back input, one write occurs every 4 cycles.
- done, err and the clearing of seq_hold are all registered. They become visible the cycle after the CHK byte is accepted.
  - done and the seq_hold clear occur in the same cycle.
  - done and err are never high together.
- The last data write (the cycle after the last data byte) always precedes done, whenever CHK arrives.
- A new START_BYTE is accepted in IDLE on the cycle after done or err.
- Reset mid-frame, asynchronous and immediate:
  - All outputs return to their reset values and any pending write is dropped.
  - Memory contents are undefined; seq_hold = 1 until a later good load.
- If in_valid is held high with the same byte, each cycle counts as a new transfer. The source must deassert in_valid or change data as its protocol requires.

## Test plan
- Single-word load:
  - Stimulus: A5 00 01 12 34 56 78 CHK=08.
  - Response: one wr_en pulse with wr_addr 0 and wr_data 32'h12345678; done pulses one cycle after CHK; seq_hold falls in the same cycle.
- Full-capacity load:
  - Stimulus: N = 512 with an incrementing pattern, back-to-back bytes.
  - Response: 512 writes, addresses 0..511 in order, every 4 cycles; done pulses; no err.
- Bad checksum:
  - Stimulus: same frame as the single-word load, but CHK=09.
  - Response: write still occurs; err pulses one cycle; seq_hold stays 1; done never asserts.
- Illegal count:
  - Stimulus: A5 00 00, then separately A5 02 01.
  - Response: err pulses after CNT_LO each time; no wr_en; loader returns to IDLE.
- Garbage and stalls:
  - Stimulus: bytes 00 FF before A5, plus random in_valid gaps inside a 3-word frame.
  - Response: leading bytes are ignored; exactly 3 correct writes; done pulses.
- Reset mid-load:
  - Stimulus: assert reset_n low after 6 data bytes of a 2-word frame, then run a fresh 1-word frame.
  - Response: outputs take reset values immediately and no second write occurs; the fresh frame then loads normally and done pulses.
